// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : multi-cycle restoring divide/remainder unit (RV32M DIV/REM)
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_b_mag;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_special;
  logic             r_done;
  logic [WIDTH-1:0] r_y;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_spec_val;
  logic [WIDTH+1:0] w_r_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_quo_res;
  logic [WIDTH-1:0] w_rem_res;
  logic [WIDTH-1:0] w_result;

  // op[0]=0 selects the signed variants, op[1]=1 selects remainder
  assign w_signed   = ~op[0];
  assign w_a_neg    = w_signed & a[WIDTH-1];
  assign w_b_neg    = w_signed & b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag    = w_b_neg ? (~b + 1'b1) : b;
  assign w_b_zero   = (b == '0);
  assign w_ovf      = w_signed & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);
  assign w_spec_val = w_b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  // Two extra bits keep the trial difference's sign visible without overflow
  assign w_r_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_diff = w_r_sh - {2'b00, r_b_mag};
  assign w_ge   = ~w_diff[WIDTH+1];

  assign w_quo_res = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_res = r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
  assign w_result  = r_special ? r_quo : (r_is_rem ? w_rem_res : w_quo_res);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_b_mag   <= '0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
      r_done    <= 1'b0;
      r_y       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_rem  <= op[1];
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_b_mag   <= w_b_mag;
            r_rem     <= '0;
            r_cnt     <= CW'(WIDTH-1);
            r_special <= w_b_zero | w_ovf;
            // Special cases park their final answer in the quotient register
            if (w_b_zero || w_ovf) begin
              r_quo   <= w_spec_val;
              r_state <= S_FIX;
            end else begin
              r_quo   <= w_a_mag;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_diff[WIDTH:0] : w_r_sh[WIDTH:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_y     <= w_result;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign y    = r_y;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// tb_seq_divider : self-checking bench for seq_divider (vectors + random)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;

  localparam int W = 32;
  localparam int NORMAL_LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] y;

  int n_checks;
  int n_err;

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_y;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  // RISC-V M-extension semantics from plain integer arithmetic
  function automatic logic [31:0] ref_result(logic [1:0] fop, logic [31:0] fa, logic [31:0] fb);
    int sa;
    int sb;
    logic ovf;
    sa  = fa;
    sb  = fb;
    ovf = (fa == 32'h8000_0000) && (fb == 32'hFFFF_FFFF);
    if (fb == 0) return fop[1] ? fa : 32'hFFFF_FFFF;
    case (fop)
      2'b00:   return ovf ? fa : 32'(sa / sb);
      2'b01:   return fa / fb;
      2'b10:   return ovf ? 32'h0 : 32'(sa % sb);
      default: return fa % fb;
    endcase
  endfunction

  function automatic int ref_latency(logic [1:0] fop, logic [31:0] fa, logic [31:0] fb);
    if (fb == 0) return 1;
    if (!fop[0] && fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) return 1;
    return NORMAL_LAT;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] lop, input logic [31:0] la, input logic [31:0] lb);
    @(negedge clk);
    op    = lop;
    a     = la;
    b     = lb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen; -1 when the budget expires
  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (!seen && done) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                        output logic [31:0] ry, output int lat);
    launch(rop, ra, rb);
    wait_done(lat);
    ry = y;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          n_done;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start    = 1'b1;
    op       = 2'b01;
    a        = 32'd5;
    b        = 32'd1;

    vecs[0] = '{2'b00, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, NORMAL_LAT};
    vecs[1] = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, NORMAL_LAT};
    vecs[2] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        NORMAL_LAT};
    vecs[3] = '{2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4,        NORMAL_LAT};
    vecs[4] = '{2'b01, 32'h1234,      32'd0,        32'hFFFF_FFFF, 1};
    vecs[5] = '{2'b11, 32'h1234,      32'd0,        32'h1234,      1};
    vecs[6] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[7] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1};
    vecs[8] = '{2'b01, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, NORMAL_LAT};
    vecs[9] = '{2'b00, 32'h8000_0000, 32'd1,        32'h8000_0000, NORMAL_LAT};

    // Reset held two edges with start asserted
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_y", y, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    run_op(2'b01, 32'd100, 32'd7, res, lat);
    check("divu_100_7_y", res, 32'd14);
    check("divu_100_7_lat", 32'(lat), 32'(NORMAL_LAT));

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_y", i), res, vecs[i].exp_y);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_busy_done", i), 32'(busy), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, res, lat);
      check($sformatf("rand%0d_y op=%0d a=%h b=%h", i, rop, ra, rb), res, ref_result(rop, ra, rb));
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'(ref_latency(rop, ra, rb)));
    end

    // Start pulse during CALC is ignored
    launch(2'b01, 32'd1000, 32'd3);
    check("midcalc_busy", 32'(busy), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    op    = 2'b11;
    a     = 32'd77;
    b     = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("midcalc_y", y, 32'd333);
    check("midcalc_lat", 32'(lat), 32'(NORMAL_LAT - 6));

    // start held through the done cycle launches a second op
    @(negedge clk);
    op    = 2'b01;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 32'd1000;
    b = 32'd3;
    wait_done(lat);
    check("b2b_first_y", y, 32'd14);
    check("b2b_first_lat", 32'(lat), 32'(NORMAL_LAT));
    check("b2b_done_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'd1);
    check("b2b_hold_y", y, 32'd14);
    check("b2b_done_pulse", 32'(done), 32'd0);
    wait_done(lat);
    check("b2b_second_y", y, 32'd333);
    check("b2b_second_lat", 32'(lat), 32'(NORMAL_LAT));

    // Reset at iteration 10 aborts the operation
    launch(2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_y", y, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    run_op(2'b01, 32'd1000, 32'd3, res, lat);
    check("after_abort_y", res, 32'd333);
    check("after_abort_lat", 32'(lat), 32'(NORMAL_LAT));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
